// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read master: default widths and FSM state encoding.
package rom_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rom_lat_counter.sv
// Loadable down-counter that times the ROM read latency.
// expire is high in the cycle whose decrement brings the count to zero,
// which is the cycle the ROM data is valid and gets captured.
module rom_lat_counter #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt;

  // load takes priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (load)           cnt <= CW'(RD_LAT);
    else if (dec && cnt != 0) cnt <= cnt - CW'(1);
  end

  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/rom_reader.sv
// ROM read master: walks an address window, one outstanding read at a time,
// streams words out over valid/ready, keeps an XOR checksum, pulses done.
module rom_reader
  import rom_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW:0]   remaining;
  logic          lat_expire;

  // counter is loaded while the read is issued and runs through WAIT
  rom_lat_counter #(.RD_LAT(RD_LAT)) u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_ISSUE),
    .dec    (state == S_WAIT),
    .expire (lat_expire)
  );

  // main FSM; all outputs registered, rom_en/rom_addr set on entry to ISSUE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            checksum <= '0;
            if (len != '0) begin
              cur_addr  <= base_addr;
              remaining <= len;
              rom_en    <= 1'b1;
              rom_addr  <= base_addr;
              busy      <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              // empty window: completes without ever going busy
              done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          rom_en <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_expire) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == (AW+1)'(1));
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            checksum  <= checksum ^ out_data;
            remaining <= remaining - (AW+1)'(1);
            cur_addr  <= cur_addr + AW'(1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (remaining == (AW+1)'(1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // address wraps naturally at 2^AW
              rom_en   <= 1'b1;
              rom_addr <= cur_addr + AW'(1);
              state    <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a latency-1 ROM model and a
// queue-based scoreboard checked by an independent monitor.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic       rom_en;
  logic [3:0] rom_addr;
  logic [3:0] rom_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [3:0] checksum;

  rom_reader #(.AW(4), .DW(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // ROM contents: a permutation of 0..F, so the XOR of all 16 words is 0
  logic [3:0] rom_tbl [16];
  initial begin
    rom_tbl[0]  = 4'h5; rom_tbl[1]  = 4'hA; rom_tbl[2]  = 4'h3; rom_tbl[3]  = 4'hC;
    rom_tbl[4]  = 4'h9; rom_tbl[5]  = 4'h6; rom_tbl[6]  = 4'hF; rom_tbl[7]  = 4'h0;
    rom_tbl[8]  = 4'h1; rom_tbl[9]  = 4'hE; rom_tbl[10] = 4'h7; rom_tbl[11] = 4'h2;
    rom_tbl[12] = 4'hB; rom_tbl[13] = 4'h4; rom_tbl[14] = 4'h8; rom_tbl[15] = 4'hD;
  end

  // latency-1 synchronous ROM
  always @(posedge clk) if (rom_en) rom_data <= rom_tbl[rom_addr];

  typedef struct packed { logic [3:0] d; logic l; } beat_t;
  logic [3:0] exp_addr [$];
  beat_t      exp_beat [$];

  int compared = 0, mismatched = 0;
  int cyc = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, prev_hs = 0;
  bit gap_chk = 0, have_prev = 0, busy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // monitor: pops the scoreboard on every ROM read and every accepted beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        en_cnt++;
        if (exp_addr.size() == 0) fail_now("unexpected rom_en");
        else chk("rom_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_beat.size() == 0) fail_now("unexpected beat");
        else begin
          beat_t b;
          b = exp_beat.pop_front();
          chk("out_data", 32'(out_data), 32'(b.d));
          chk("out_last", 32'(out_last), 32'(b.l));
        end
        if (gap_chk && have_prev) chk("beat_gap", 32'(cyc - prev_hs), 32'd3);
        prev_hs   = cyc;
        have_prev = 1;
        last_hs   = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] d, input logic l);
    exp_addr.push_back(a);
    exp_beat.push_back('{d: d, l: l});
  endtask

  task automatic pulse_start(input logic [3:0] b, input logic [4:0] n);
    start = 1'b1; base_addr = b; len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 50 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!out_valid) fail_now({name, " timeout waiting out_valid"});
  endtask

  task automatic finish_window(input string name, input logic [3:0] exp_sum, input bit hs);
    int d0 = done_cnt;
    for (int k = 0; k < 200 && done_cnt == d0; k++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == d0) fail_now({name, " timeout waiting done"});
    else if (hs) chk({name, " done_after_hs"}, 32'(done_cyc), 32'(last_hs + 1));
    chk({name, " checksum"}, 32'(checksum), 32'(exp_sum));
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " pending"}, 32'(exp_addr.size() + exp_beat.size()), 32'd0);
  endtask

  initial begin
    int k, en0, d0;
    // reset state
    @(posedge clk); #1;
    chk("reset ctl", {28'd0, rom_en, out_valid, busy, done}, 32'd0);
    chk("reset data", {20'd0, rom_addr, out_data, checksum}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic read, latency and spacing
    out_ready = 1'b1;
    push(4'h2, 4'h3, 0); push(4'h3, 4'hC, 0); push(4'h4, 4'h9, 1);
    gap_chk = 1; have_prev = 0;
    pulse_start(4'h2, 5'd3);
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("first_latency", 32'(k), 32'd3);
    finish_window("basic", 4'h6, 1);
    gap_chk = 0;

    // backpressure
    out_ready = 1'b0;
    push(4'h0, 4'h5, 0); push(4'h1, 4'hA, 1);
    en0 = en_cnt;
    pulse_start(4'h0, 5'd2);
    wait_valid("bp");
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold data", 32'(out_data), 32'h5);
    end
    chk("bp single read", 32'(en_cnt - en0), 32'd1);
    out_ready = 1'b1;
    finish_window("bp", 4'hF, 1);

    // wrap around the top of the address space
    push(4'hE, 4'h8, 0); push(4'hF, 4'hD, 0); push(4'h0, 4'h5, 0); push(4'h1, 4'hA, 1);
    pulse_start(4'hE, 5'd4);
    finish_window("wrap", 4'hA, 1);

    // len 0: done without busy, checksum cleared from A
    busy_seen = 0;
    d0 = done_cnt;
    pulse_start(4'h3, 5'd0);
    finish_window("len0", 4'h0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("len0 busy_seen", 32'(busy_seen), 32'd0);
    chk("len0 done pulses", 32'(done_cnt - d0), 32'd1);

    // full window
    for (int i = 0; i < 16; i++) push(4'(i), rom_tbl[i], i == 15);
    pulse_start(4'h0, 5'd16);
    finish_window("len16", 4'h0, 1);

    // start while busy is ignored
    push(4'h1, 4'hA, 0); push(4'h2, 4'h3, 0); push(4'h3, 4'hC, 1);
    pulse_start(4'h1, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(4'h9, 5'd3);
    finish_window("busy_start", 4'h5, 1);
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_start idle busy", 32'(busy), 32'd0);
    chk("busy_start no extra done", 32'(done_cnt - d0), 32'd0);

    // reset while holding the second word
    out_ready = 1'b0;
    exp_addr.push_back(4'h4); exp_beat.push_back('{d: 4'h9, l: 1'b0});
    exp_addr.push_back(4'h5);
    pulse_start(4'h4, 5'd3);
    wait_valid("rst first");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid("rst second");
    chk("rst pre checksum", 32'(checksum), 32'h9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("rst no done", 32'(done_cnt - d0), 32'd0);
    chk("rst pending", 32'(exp_addr.size() + exp_beat.size()), 32'd0);

    // fresh start after reset
    out_ready = 1'b1;
    push(4'h9, 4'hE, 1);
    pulse_start(4'h9, 5'd1);
    finish_window("fresh", 4'hE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
- Read master for the rom_design port (clk, en, addr, data): walks a programmed address window and streams the fetched words out over a valid/ready interface.
- Drives en/addr, waits the fixed ROM read latency, captures data, and presents it downstream with backpressure.
- Keeps a running XOR checksum of the words and pulses done when the window is exhausted.
- Sits between the ROM and any consumer (UART tx, display driver, checker).

Parameters:
- AW, 4, ROM address width.
- DW, 4, ROM data width.
- RD_LAT, 1, ROM read latency in cycles from en/addr sampled to data valid (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  AW  first ROM address, sampled with start.
- len  in  AW+1  number of words to read, 0..2^AW, sampled with start.
- rom_en  out  1  ROM enable.
- rom_addr  out  AW  ROM address.
- rom_data  in  DW  ROM read data.
- out_valid  out  1  out_data holds a fetched word.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_data  out  DW  fetched word.
- out_last  out  1  high with out_valid on the final word of the window.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the window completes.
- checksum  out  DW  XOR of all words accepted in the current/last window.

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE; rom_en, rom_addr, out_valid, out_data, out_last, busy, done and checksum all 0; internal address and remaining counters cleared.
- Reset mid-transfer aborts immediately: no done pulse, and the partial word is discarded.
- States:
  - IDLE
    - start=1, len≠0: latch base_addr→cur_addr and len→remaining; clear checksum; go to ISSUE.
    - start=1, len=0: clear checksum, pulse done next cycle, stay IDLE.
  - ISSUE: rom_en=1, rom_addr=cur_addr for exactly one cycle; load lat_cnt=RD_LAT; go to WAIT.
  - WAIT: rom_en=0; decrement lat_cnt; when it reaches 0, capture rom_data into out_data, set out_valid=1, out_last=(remaining==1), go to HOLD.
  - HOLD: out_valid held with out_data stable until out_ready=1. On the handshake:
    - checksum ^= out_data.
    - remaining -= 1.
    - cur_addr += 1, wrapping modulo 2^AW (e.g. base 4'hF, len 2 reads F then 0).
    - out_valid drops the next cycle.
    - If remaining was 1: go to DONE. Otherwise go to ISSUE.
  - DONE: done=1 for one cycle, busy=0 from the following cycle; go to IDLE.
- Timing:
  - Latency from start to first out_valid is RD_LAT+2 cycles.
  - With out_ready held high, words are spaced RD_LAT+2 cycles apart.
- start while busy is ignored, with no effect on the transfer.
- A start in the same cycle as the DONE→IDLE transition is ignored; start is only sampled while in IDLE.
- out_ready while out_valid=0 has no effect.
- checksum holds its value after done until the next accepted start.
- rom_en is never high in WAIT or HOLD, so the ROM sees at most one outstanding read.

Decomposition:
- Shared package rom_pkg:
  - Default AW/DW.
  - State encoding localparams S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE.
- One natural sub-module: rom_lat_counter, a loadable down-counter sized to RD_LAT with a zero flag, used for the WAIT phase.
- Everything else stays inline.
- The bench instantiates rom_design as the ROM model.

Test Plan:
- Basic read: base 4'h2, len 3, out_ready=1 → rom_addr sequence 2,3,4; three out_valid beats with the ROM contents at 2,3,4; out_last on the third beat; done 1 cycle after the last handshake; checksum = XOR of the three words.
- Backpressure: base 4'h0, len 2, out_ready=0 for 7 cycles after the first out_valid → out_data stable, no second rom_en until the handshake; the sequence then completes normally.
- Wrap: base 4'hE, len 4 → addresses E,F,0,1; out_last on the address-1 word.
- Boundary lengths:
  - len 0 → done pulse with busy never high; checksum 0.
  - len 16, base 0 → all 16 addresses read once.
- Start while busy: second start (base 4'h9) mid-transfer of base 4'h1 len 3 → ignored; addresses stay 1,2,3.
- Reset mid-operation: rst_n low during HOLD → next cycle out_valid=0, busy=0, done=0, checksum=0; a fresh start then works.
